// File: rtl/energy_cal_pkg.sv
// Shared constants and payload types for the energy calibration polynomial evaluator.
package energy_cal_pkg;

  localparam int unsigned RESID_W = 10;
  localparam int unsigned COEF_W  = 64;
  localparam int unsigned VALUE_W = 16;
  localparam int unsigned CNT_W16 = 16;

  // Coefficient word layout: a = s16, b = s24, c = s24
  localparam int unsigned A_MSB = 63;
  localparam int unsigned A_LSB = 48;
  localparam int unsigned A_W   = 16;
  localparam int unsigned B_MSB = 47;
  localparam int unsigned B_LSB = 24;
  localparam int unsigned B_W   = 24;
  localparam int unsigned C_MSB = 23;
  localparam int unsigned C_LSB = 0;
  localparam int unsigned C_W   = 24;

  localparam int unsigned BRAM_LAT = 2;
  localparam int unsigned PIPE_LAT = 6;
  localparam int unsigned SHIFT_A  = 30;
  localparam int unsigned SHIFT_B  = 15;

  typedef struct packed {
    logic [RESID_W-1:0] resid;
    logic [VALUE_W-1:0] value;
  } energy_t;

  function automatic logic [CNT_W16-1:0] sat_inc(input logic [CNT_W16-1:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/energy_cal_out_fifo.sv
// First-word-fall-through output FIFO with occupancy count.
module energy_cal_out_fifo
  import energy_cal_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  energy_t                wr_data,
  input  logic                   rd_en,
  output energy_t                rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  energy_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_ok;

  assign rd_ok    = rd_en && (count != '0);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_ok)      count <= count + CW'(1);
      else if (!wr_en && rd_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/energy_cal_poly_eval.sv
// Per-photon energy = a*p^2 + b*p + c from a BRAM coefficient table, clamped to 16 bits.
// Optional ENERGY_CAL_UNCAL_DROP_EN: drop events whose coefficient word is zero, count them.
module energy_cal_poly_eval
  import energy_cal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PHASE_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  photon_valid,
  output logic                  photon_ready,
  input  logic [RESID_W-1:0]    photon_resid,
  input  logic [PHASE_W-1:0]    photon_phase,
  output logic                  bram_en_a,
  output logic                  bram_we,
  output logic [RESID_W-1:0]    bram_addr,
  output logic [COEF_W-1:0]     bram_wr_data,
  input  logic [COEF_W-1:0]     bram_rd_data,
  output logic                  energy_valid,
  input  logic                  energy_ready,
  output logic [RESID_W-1:0]    energy_resid,
  output logic [VALUE_W-1:0]    energy_value,
`ifdef ENERGY_CAL_UNCAL_DROP_EN
  output logic [CNT_W16-1:0]    drop_count,
`endif
  output logic [CNT_W16-1:0]    sat_count
);

  localparam int unsigned PP_W   = 2 * PHASE_W;
  localparam int unsigned BP_W   = B_W + PHASE_W;
  localparam int unsigned AP_W   = A_W + PP_W;
  localparam int unsigned SUM_W  = ((AP_W > BP_W) ? AP_W : BP_W) + 2;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRED_W = CNT_W + 1;
  localparam int unsigned NSTG   = PIPE_LAT - 1;

  logic                                accept;
  logic [NSTG:1]                       vld;
  logic [CNT_W-1:0]                    fifo_count;
  logic [CRED_W-1:0]                   credit;
  logic                                fifo_wr;
  energy_t                             fifo_din;
  energy_t                             fifo_dout;

  logic [BRAM_LAT-1:0][RESID_W-1:0]    resid_d;
  logic [BRAM_LAT-1:0][PHASE_W-1:0]    phase_d;
  logic signed [A_W-1:0]               a3, a4;
  logic signed [B_W-1:0]               b3;
  logic signed [C_W-1:0]               c3, c4, c5;
  logic signed [PHASE_W-1:0]           p3;
  logic signed [PP_W-1:0]              pp4;
  logic signed [BP_W-1:0]              bp4, bp5;
  logic signed [AP_W-1:0]              ap5;
  logic [RESID_W-1:0]                  r3, r4, r5;

  logic signed [SUM_W-1:0]             sum_c;
  logic                                neg_c;
  logic                                over_c;
  logic [VALUE_W-1:0]                  value_c;

  // Credit covers everything in flight plus FIFO contents, so the FIFO can never overflow
  assign accept       = photon_valid & photon_ready;
  assign credit       = CRED_W'(fifo_count) + CRED_W'($countones(vld));
  assign photon_ready = !rst && (credit < CRED_W'(FIFO_DEPTH));

  assign bram_en_a    = accept;
  assign bram_we      = 1'b0;
  assign bram_addr    = photon_resid;
  assign bram_wr_data = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[NSTG-1:1], accept};
  end

  always_ff @(posedge clk) begin
    resid_d <= {resid_d[BRAM_LAT-2:0], photon_resid};
    phase_d <= {phase_d[BRAM_LAT-2:0], photon_phase};
    a3  <= bram_rd_data[A_MSB:A_LSB];
    b3  <= bram_rd_data[B_MSB:B_LSB];
    c3  <= bram_rd_data[C_MSB:C_LSB];
    p3  <= $signed(phase_d[BRAM_LAT-1]);
    r3  <= resid_d[BRAM_LAT-1];
    pp4 <= PP_W'(p3) * PP_W'(p3);
    bp4 <= BP_W'(b3) * BP_W'(p3);
    a4  <= a3;
    c4  <= c3;
    r4  <= r3;
    ap5 <= AP_W'(a4) * AP_W'(pp4);
    bp5 <= bp4;
    c5  <= c4;
    r5  <= r4;
  end

  always_comb begin
    sum_c   = SUM_W'(ap5 >>> SHIFT_A) + SUM_W'(bp5 >>> SHIFT_B) + SUM_W'(c5);
    neg_c   = sum_c[SUM_W-1];
    over_c  = !neg_c && (|sum_c[SUM_W-2:VALUE_W]);
    value_c = sum_c[VALUE_W-1:0];
    if (neg_c)       value_c = '0;
    else if (over_c) value_c = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             sat_count <= '0;
    else if (vld[NSTG] && (neg_c || over_c)) sat_count <= sat_inc(sat_count);
  end

`ifdef ENERGY_CAL_UNCAL_DROP_EN
  // Zero-word flag rides alongside stages 3..5; dropped slots free their credit at stage 5
  logic [2:0] zero_d;

  always_ff @(posedge clk) begin
    zero_d <= {zero_d[1:0], (bram_rd_data == '0)};
  end

  assign fifo_wr = vld[NSTG] & ~zero_d[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         drop_count <= '0;
    else if (vld[NSTG] && zero_d[2]) drop_count <= sat_inc(drop_count);
  end
`else
  assign fifo_wr = vld[NSTG];
`endif

  assign fifo_din.resid = r5;
  assign fifo_din.value = value_c;

  energy_cal_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_din),
    .rd_en    (energy_ready),
    .rd_data  (fifo_dout),
    .rd_valid (energy_valid),
    .count    (fifo_count)
  );

  assign energy_resid = fifo_dout.resid;
  assign energy_value = fifo_dout.value;

endmodule

// File: tb/tb_energy_cal_poly_eval.sv
// Scoreboard bench for energy_cal_poly_eval; build with ENERGY_CAL_UNCAL_DROP_EN to cover dropping.
module tb_energy_cal_poly_eval;
  import energy_cal_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        photon_valid = 1'b0;
  logic        photon_ready;
  logic [9:0]  photon_resid = '0;
  logic [15:0] photon_phase = '0;
  logic        bram_en_a;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [63:0] bram_wr_data;
  logic [63:0] bram_rd_data;
  logic        energy_valid;
  logic        energy_ready = 1'b1;
  logic [9:0]  energy_resid;
  logic [15:0] energy_value;
  logic [15:0] sat_count;
`ifdef ENERGY_CAL_UNCAL_DROP_EN
  logic [15:0] drop_count;
`endif

  energy_cal_poly_eval #(.FIFO_DEPTH(DEPTH), .PHASE_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .photon_valid (photon_valid),
    .photon_ready (photon_ready),
    .photon_resid (photon_resid),
    .photon_phase (photon_phase),
    .bram_en_a    (bram_en_a),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_data (bram_rd_data),
    .energy_valid (energy_valid),
    .energy_ready (energy_ready),
    .energy_resid (energy_resid),
    .energy_value (energy_value),
`ifdef ENERGY_CAL_UNCAL_DROP_EN
    .drop_count   (drop_count),
`endif
    .sat_count    (sat_count)
  );

  always #5 clk = ~clk;

  // Coefficient BRAM: registered read with two cycles of latency
  logic [63:0] coef_mem [1024];
  logic [63:0] bram_pipe;
  always @(posedge clk) begin
    if (bram_en_a) bram_pipe <= coef_mem[bram_addr];
    bram_rd_data <= bram_pipe;
  end

  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        n_pops   = 0;
  int        batch_first = -1;
  int        batch_last  = -1;
  logic [15:0] exp_sat  = '0;
  logic [15:0] exp_drop = '0;
  bit        rand_ready = 1'b0;
  energy_t   q[$];
  energy_t   mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_ready) energy_ready = 1'($urandom_range(0, 1));
  end

  function automatic void model(input logic [63:0] w, input logic [15:0] ph,
                                output logic [15:0] v, output bit clamped);
    longint a, b, c, p, s;
    a = longint'($signed(w[63:48]));
    b = longint'($signed(w[47:24]));
    c = longint'($signed(w[23:0]));
    p = longint'($signed(ph));
    s = ((a * p * p) >>> 30) + ((b * p) >>> 15) + c;
    clamped = 1'b1;
    if (s < 0)           v = 16'd0;
    else if (s > 65535)  v = 16'hFFFF;
    else begin
      v = 16'(s);
      clamped = 1'b0;
    end
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output
  always @(negedge clk) begin
    logic [15:0] v;
    bit          cl;
    logic [63:0] w;
    if (rst) begin
      q.delete();
      exp_sat  = '0;
      exp_drop = '0;
    end else begin
      if (energy_valid && energy_ready) begin
        n_checks++;
        n_pops++;
        if (batch_first < 0) batch_first = cyc;
        batch_last = cyc;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got resid=%0d value=%0d, required no output",
                   energy_resid, energy_value);
        end else begin
          mon_e = q.pop_front();
          if ({energy_resid, energy_value} !== mon_e) begin
            n_fail++;
            $display("FAIL result: got resid=%0d value=%0d, required resid=%0d value=%0d",
                     energy_resid, energy_value, mon_e.resid, mon_e.value);
          end
        end
      end
      if (photon_valid && photon_ready) begin
        w = coef_mem[photon_resid];
`ifdef ENERGY_CAL_UNCAL_DROP_EN
        if (w == '0) begin
          if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end else begin
`else
        begin
`endif
          model(w, photon_phase, v, cl);
          if (cl && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
          q.push_back({photon_resid, v});
        end
      end
    end
  end

  task automatic send(input logic [9:0] r, input logic [15:0] p);
    bit acc;
    int guard;
    photon_valid = 1'b1;
    photon_resid = r;
    photon_phase = p;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = photon_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    photon_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: resid=%0d not accepted within %0d cycles", r, guard);
    end
  endtask

  task automatic wait_drain();
    int guard;
    energy_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (photon_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b required 0", photon_ready);
    end
    n_checks++;
    if (energy_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b required 0", energy_valid);
    end
    n_checks++;
    if (sat_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_sat: got %0d required 0", sat_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (photon_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b required 1", photon_ready);
    end
`ifdef ENERGY_CAL_UNCAL_DROP_EN
    n_checks++;
    if (drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_drop: got %0d required 0", drop_count);
    end
`endif
  endtask

  task automatic test_basic();
    int n;
    coef_mem[1] = {16'h0000, 24'h008000, 24'd1000};
    @(posedge clk);
    #1;
    energy_ready = 1'b1;
    photon_valid = 1'b1;
    photon_resid = 10'd1;
    photon_phase = 16'h4000;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      photon_valid = 1'b0;
      if (energy_valid) break;
    end
    n_checks++;
    if (n != PIPE_LAT) begin
      n_fail++; $display("FAIL latency: got %0d cycles required %0d", n, PIPE_LAT);
    end
    n_checks++;
    if (energy_value !== 16'd17384 || energy_resid !== 10'd1) begin
      n_fail++;
      $display("FAIL basic_value: got resid=%0d value=%0d required resid=1 value=17384",
               energy_resid, energy_value);
    end
    n_checks++;
    if (bram_we !== 1'b0 || bram_wr_data !== 64'd0) begin
      n_fail++; $display("FAIL bram_write: got we=%b data=%h required 0", bram_we, bram_wr_data);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    coef_mem[5] = {16'h0000, 24'h000000, 24'hFFFFFB};
    coef_mem[6] = {16'h0000, 24'h000000, 24'h7FFFFF};
    send(10'd5, 16'(($urandom)));
    send(10'd6, 16'(($urandom)));
    wait_drain();
    n_checks++;
    if (sat_count !== 16'd2) begin
      n_fail++; $display("FAIL sat_count: got %0d required 2", sat_count);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(10'($urandom_range(10, 60)), 16'($urandom));
    @(posedge clk);
    #1 rand_ready = 1'b0;
    wait_drain();
    n_checks++;
    if (sat_count !== exp_sat) begin
      n_fail++; $display("FAIL random_sat: got %0d required %0d", sat_count, exp_sat);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [9:0]  held_r;
    logic [15:0] held_v;
    acc = 0;
    energy_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      photon_valid = 1'b1;
      photon_resid = 10'(200 + k);
      photon_phase = 16'($urandom);
      @(negedge clk);
      if (photon_ready) acc++;
      if (k == 10) begin
        held_r = energy_resid;
        held_v = energy_value;
      end
      if (k == 18) begin
        n_checks++;
        if (energy_resid !== held_r || energy_value !== held_v || energy_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL hold: got valid=%b resid=%0d value=%0d required 1 %0d %0d",
                   energy_valid, energy_resid, energy_value, held_r, held_v);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (acc != DEPTH) begin
      n_fail++; $display("FAIL stall_accepts: got %0d required %0d", acc, DEPTH);
    end
    n_checks++;
    if (photon_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready: got %b required 0", photon_ready);
    end
    photon_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int c0, c1, p0;
    energy_ready = 1'b1;
    batch_first = -1;
    p0 = n_pops;
    c0 = cyc;
    for (int i = 0; i < 100; i++)
      send(10'(300 + i), 16'($urandom));
    c1 = cyc;
    wait_drain();
    n_checks++;
    if (c1 - c0 != 100) begin
      n_fail++; $display("FAIL input_rate: got %0d cycles required 100", c1 - c0);
    end
    n_checks++;
    if (n_pops - p0 != 100) begin
      n_fail++; $display("FAIL b2b_count: got %0d required 100", n_pops - p0);
    end
    n_checks++;
    if (batch_last - batch_first != 99) begin
      n_fail++; $display("FAIL output_rate: got span %0d required 99", batch_last - batch_first);
    end
    n_checks++;
    if (sat_count !== exp_sat) begin
      n_fail++; $display("FAIL b2b_sat: got %0d required %0d", sat_count, exp_sat);
    end
  endtask

  task automatic test_uncal();
    int p0;
    coef_mem[7] = 64'd0;
    p0 = n_pops;
    send(10'd7, 16'h1234);
    repeat (12) @(posedge clk);
    #1;
`ifdef ENERGY_CAL_UNCAL_DROP_EN
    n_checks++;
    if (drop_count !== 16'd1 || n_pops != p0) begin
      n_fail++;
      $display("FAIL drop: got drop_count=%0d outputs=%0d required 1 and 0", drop_count, n_pops - p0);
    end
`else
    n_checks++;
    if (n_pops - p0 != 1) begin
      n_fail++; $display("FAIL uncal_emit: got %0d outputs required 1", n_pops - p0);
    end
`endif
    n_checks++;
    if (photon_ready !== 1'b1) begin
      n_fail++; $display("FAIL uncal_credit: got ready=%b required 1", photon_ready);
    end
    send(10'd1, 16'h4000);
    wait_drain();
  endtask

  task automatic test_reset_flight();
    int nv;
    energy_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(10'(400 + i), 16'($urandom));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (energy_valid !== 1'b0 || photon_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got valid=%b ready=%b required 0 0", energy_valid, photon_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (sat_count !== 16'd0 || photon_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got sat=%0d ready=%b required 0 1", sat_count, photon_ready);
    end
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (energy_valid) nv++;
    end
    n_checks++;
    if (nv != 0) begin
      n_fail++; $display("FAIL flight_discard: got %0d valid cycles required 0", nv);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      coef_mem[i] = {16'($urandom),
                     24'($urandom_range(0, 32767)) - 24'd16384,
                     24'($urandom_range(0, 40000))};
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_uncal();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
